shot_clock_ctrl: RTL
====================

// Module: shot_clock_ctrl
// PURPOSE
// Game sequencer for the four-digit seven-segment display: owns the shot-clock countdown
// (d1:d0) and the made-shot score (d3:d2), and generates the scan_en strobe.
// Drives sevenseg_mux directly: scan_en, d3..d0 connect straight across.
// Digit code 4'hF = blank (sevenseg_mux encoder).
// PARAMETERS
// SCAN_DIV   100_000      clk cycles per scan_en pulse (1 kHz at 100 MHz)
// TICK_DIV   100_000_000  clk cycles per countdown second
// BLINK_DIV  50_000_000   clk cycles per half-period of expiry flash
// START_TENS 4'd1         reload value, timer tens digit (BCD 0-9)
// START_ONES 4'd0         reload value, timer ones digit (BCD 0-9)
// PORTS
// clk        in   1  system clock, 100 MHz
// rst        in   1  synchronous, active-low reset (0 = reset)
// start      in   1  1-cycle pulse: load START value and begin countdown
// pause      in   1  1-cycle pulse: toggle RUN <-> PAUSED
// clear      in   1  1-cycle pulse: return to IDLE, reload timer, zero score
// shot_made  in   1  1-cycle pulse: score +1 (counted only in RUN)
// scan_en    out  1  1-cycle strobe every SCAN_DIV clocks, to sevenseg_mux
// d3         out  4  score tens (BCD), 4'hF when score < 10
// d2         out  4  score ones (BCD)
// d1         out  4  timer tens (BCD), or 4'hF during flash-off phase
// d0         out  4  timer ones (BCD), or 4'hF during flash-off phase
// time_up    out  1  1-cycle pulse when timer reaches 00
// running    out  1  high while state == RUN
// BEHAVIOUR
// - Reset (rst==0 at posedge): state IDLE; scan_en 0; time_up 0; running 0;
//   timer = START_TENS:START_ONES; score = 00; d3=F d2=0 d1=START_TENS d0=START_ONES;
//   all prescalers (scan, tick, blink) cleared to 0. Reset mid-run aborts with no time_up.
// - scan_en: free-running counter 0..SCAN_DIV-1, pulse when count==SCAN_DIV-1; runs in
//   every state; first pulse SCAN_DIV cycles after reset release.
// - FSM: IDLE, RUN, PAUSED, EXPIRED. Command priority same cycle: clear > start > pause.
//   IDLE:    start -> RUN (reload timer, tick counter=0). pause ignored.
//   RUN:     tick counter increments; at TICK_DIV-1 -> 1 s tick, counter wraps to 0.
//            On tick: BCD decrement (ones 0 -> 9 with tens-1). If result 00 -> EXPIRED,
//            time_up=1 for that cycle. pause -> PAUSED. start -> reload, restart RUN.
//   PAUSED:  tick counter frozen (keeps value); pause -> RUN resumes from held count;
//            start -> reload, RUN.
//   EXPIRED: timer held 00; blink counter toggles flash phase every BLINK_DIV clocks,
//            phase starts "on"; off phase d1=d0=F. start -> reload, RUN; pause ignored.
//   clear in any state -> IDLE, timer reloaded, score 00, tick/blink counters 0.
// - Score: BCD 00..99, increments on shot_made only in RUN (incl. cycle of expiring
//   tick); saturates at 99; shot_made in IDLE/PAUSED/EXPIRED ignored; clear+shot_made
//   same cycle -> score 00.
// - Outputs d3..d0, running registered: reflect internal state one clk after the edge
//   that changed it. time_up asserted in the same cycle state becomes EXPIRED.
// - START value 00: start -> EXPIRED directly with time_up pulse next cycle.
// TESTING (bench params SCAN_DIV=4, TICK_DIV=10, BLINK_DIV=5)
// 1 Reset: hold rst=0 5 cycles -> d3=F d2=0 d1=1 d0=0, scan_en 0; after release scan_en
//   pulses every 4 clks exactly.
// 2 start, no other input -> d1:d0 goes 10,09,...,01,00 one step per 10 clks; time_up
//   single pulse at 00; running drops; d1/d0 alternate 00/FF every 5 clks.
// 3 start, pause at timer 07 held 23 clks, pause again -> resumes, 07->06 arrives after
//   the remaining tick count (no lost or extra cycles).
// 4 Score: 9 shot_made in RUN -> d3=F d2=9; 10th -> d3=1 d2=0; 100 pulses -> holds 99;
//   shot_made while PAUSED/EXPIRED -> unchanged.
// 5 Priority: clear+start same cycle in RUN -> IDLE, 10/00 shown; start+pause -> reload,
//   RUN; shot_made on expiring tick -> counted.
// 6 rst=0 mid-RUN at timer 04 -> reset values next cycle, no time_up pulse.

Source files
------------

// File: rtl/shot_clock_ctrl.sv
// -----------------------------------------------------------------------------
// shot_clock_ctrl
//
// Game sequencer for a four-digit seven-segment display. Owns the shot-clock
// countdown (shown on d1:d0) and the made-shot score (shown on d3:d2), and
// generates the scan_en strobe that paces the display multiplexer. The digit
// outputs connect straight across to sevenseg_mux; digit code 4'hF is blank.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active low (0 = reset)
//   start      in   1  pulse: load the start value and begin counting down
//   pause      in   1  pulse: toggle RUN <-> PAUSED
//   clear      in   1  pulse: back to IDLE, timer reloaded, score zeroed
//   shot_made  in   1  pulse: score +1, counted only while running
//   scan_en    out  1  one-cycle strobe every SCAN_DIV clocks
//   d3         out  4  score tens (BCD), blank while score < 10
//   d2         out  4  score ones (BCD)
//   d1         out  4  timer tens (BCD), blank in the flash-off phase
//   d0         out  4  timer ones (BCD), blank in the flash-off phase
//   time_up    out  1  one-cycle pulse when the timer reaches 00
//   running    out  1  high while the sequencer is in RUN
// -----------------------------------------------------------------------------
module shot_clock_ctrl #(
    parameter int unsigned SCAN_DIV   = 100_000,
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned BLINK_DIV  = 50_000_000,
    parameter logic [3:0]  START_TENS = 4'd1,
    parameter logic [3:0]  START_ONES = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       shot_made,
    output logic       scan_en,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       time_up,
    output logic       running
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [3:0] BLANK      = 4'hF;
    localparam bit         START_ZERO = (START_TENS == 4'd0) && (START_ONES == 4'd0);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    state_t             state;
    logic [3:0]         t_tens;
    logic [3:0]         t_ones;
    logic [3:0]         s_tens;
    logic [3:0]         s_ones;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               flash_on;

    // NOTE: every register here uses <=, so all right-hand sides see the values
    // from before this edge. That is what makes d3..d0 and running trail the
    // internal state by exactly one clock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            t_tens    <= START_TENS;
            t_ones    <= START_ONES;
            s_tens    <= 4'd0;
            s_ones    <= 4'd0;
            scan_cnt  <= '0;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            flash_on  <= 1'b1;
            scan_en   <= 1'b0;
            time_up   <= 1'b0;
            running   <= 1'b0;
            d3        <= BLANK;
            d2        <= 4'd0;
            d1        <= START_TENS;
            d0        <= START_ONES;
        end else begin
            // Display scan prescaler runs in every state.
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_en  <= 1'b1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
                scan_en  <= 1'b0;
            end

            // Registered view of the state as it stood before this edge.
            running <= (state == RUN);
            d3      <= (s_tens == 4'd0) ? BLANK : s_tens;
            d2      <= s_ones;
            d1      <= (state == EXPIRED && !flash_on) ? BLANK : t_tens;
            d0      <= (state == EXPIRED && !flash_on) ? BLANK : t_ones;

            time_up <= 1'b0;

            // Score: clear wins over a simultaneous shot; saturates at 99.
            if (clear) begin
                s_tens <= 4'd0;
                s_ones <= 4'd0;
            end else if (shot_made && state == RUN &&
                         !(s_tens == 4'd9 && s_ones == 4'd9)) begin
                if (s_ones == 4'd9) begin
                    s_ones <= 4'd0;
                    s_tens <= s_tens + 4'd1;
                end else begin
                    s_ones <= s_ones + 4'd1;
                end
            end

            // Sequencer. Command priority: clear > start > pause.
            if (clear) begin
                state     <= IDLE;
                t_tens    <= START_TENS;
                t_ones    <= START_ONES;
                tick_cnt  <= '0;
                blink_cnt <= '0;
                flash_on  <= 1'b1;
            end else if (start) begin
                t_tens    <= START_TENS;
                t_ones    <= START_ONES;
                tick_cnt  <= '0;
                blink_cnt <= '0;
                flash_on  <= 1'b1;
                if (START_ZERO) begin
                    state   <= EXPIRED;
                    time_up <= 1'b1;
                end else begin
                    state   <= RUN;
                end
            end else begin
                case (state)
                    RUN: begin
                        // The cycle that carries a pause pulse is still a
                        // running cycle, so it advances the tick count; the
                        // count is then frozen until the resuming pulse.
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (t_ones == 4'd0) begin
                                t_ones <= 4'd9;
                                t_tens <= t_tens - 4'd1;
                            end else begin
                                t_ones <= t_ones - 4'd1;
                            end
                            // Expiry takes precedence over a pause on the same edge.
                            if (t_tens == 4'd0 && t_ones == 4'd1) begin
                                state     <= EXPIRED;
                                time_up   <= 1'b1;
                                blink_cnt <= '0;
                                flash_on  <= 1'b1;
                            end else if (pause) begin
                                state <= PAUSED;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                            if (pause) begin
                                state <= PAUSED;
                            end
                        end
                    end
                    PAUSED: begin
                        if (pause) begin
                            state <= RUN;
                        end
                    end
                    EXPIRED: begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            flash_on  <= ~flash_on;
                        end else begin
                            blink_cnt <= blink_cnt + BLINK_W'(1);
                        end
                    end
                    default: begin
                        // IDLE: wait for start; pause and shots are ignored.
                    end
                endcase
            end
        end
    end

endmodule
